// File: rtl/seq_booth_divider.sv
// Iterative signed divider (truncating): 2W-bit dividend / W-bit divisor -> W-bit quotient and remainder.
// Optional macro DIV_DBZ_FLAG_EN adds a dbz output flagging divide-by-zero alongside ovf.
//
// state | meaning
// IDLE  | waiting for start; operands and signs captured on accept
// LOAD  | form magnitudes, detect divide-by-zero / early overflow
// CALC  | BITWIDTH restoring-division steps, one quotient bit per cycle
// SIGN  | apply signs, range check / saturate, pulse done
module seq_booth_divider #(
  parameter int BITWIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [2*BITWIDTH-1:0]   dividend,
  input  logic [BITWIDTH-1:0]     divisor,
  output logic                    busy,
  output logic                    done,
  output logic [BITWIDTH-1:0]     quotient,
  output logic [BITWIDTH-1:0]     remainder,
`ifdef DIV_DBZ_FLAG_EN
  output logic                    dbz,
`endif
  output logic                    ovf
);

  localparam int W  = BITWIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] LAST    = CW'(W - 1);
  localparam logic [W-1:0]  MAX_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  MIN_MAG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, LOAD, CALC, SIGN} state_t;
  state_t state, state_nxt;

  logic [2*W-1:0] dvd_r, dvd_mag, acc;
  logic [W-1:0]   dvs_r, dvs_mag, mag_d;
  logic           sign_n, sign_d, ovf_pend;
  logic [CW-1:0]  cnt;

  logic           accept, early_ovf, fits, q_neg, sat_neg, dbz_c, range_ovf, ovf_c;
  logic [W:0]     top;
  logic [W-1:0]   diff, q_mag, r_mag;

  // start is ignored during the done cycle so the next accept lands one cycle later
  assign accept    = (state == IDLE) && start && !done;
  assign busy      = (state != IDLE);

  assign dvd_mag   = dvd_r[2*W-1] ? (~dvd_r + 1'b1) : dvd_r;
  assign dvs_mag   = dvs_r[W-1]   ? (~dvs_r + 1'b1) : dvs_r;
  assign early_ovf = (dvs_mag == '0) || (dvd_mag[2*W-1:W] >= dvs_mag);

  assign top       = acc[2*W-1:W-1];
  assign fits      = (top >= {1'b0, mag_d});
  assign diff      = top[W-1:0] - mag_d;

  assign q_mag     = acc[W-1:0];
  assign r_mag     = acc[2*W-1:W];
  assign q_neg     = sign_n ^ sign_d;
  assign dbz_c     = (mag_d == '0);
  assign sat_neg   = dbz_c ? sign_n : q_neg;
  assign range_ovf = q_neg ? (q_mag > MIN_MAG) : (q_mag > MAX_POS);
  assign ovf_c     = ovf_pend | range_ovf;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    state_nxt = early_ovf ? SIGN : CALC;
      CALC:    if (cnt == LAST) state_nxt = SIGN;
      SIGN:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done      <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      ovf       <= 1'b0;
`ifdef DIV_DBZ_FLAG_EN
      dbz       <= 1'b0;
`endif
      dvd_r     <= '0;
      dvs_r     <= '0;
      sign_n    <= 1'b0;
      sign_d    <= 1'b0;
      acc       <= '0;
      mag_d     <= '0;
      ovf_pend  <= 1'b0;
      cnt       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd_r  <= dividend;
            dvs_r  <= divisor;
            sign_n <= dividend[2*W-1];
            sign_d <= divisor[W-1];
          end
        end
        LOAD: begin
          acc      <= dvd_mag;
          mag_d    <= dvs_mag;
          ovf_pend <= early_ovf;
          cnt      <= '0;
        end
        CALC: begin
          if (fits) acc <= {diff, acc[W-2:0], 1'b1};
          else      acc <= {acc[2*W-2:0], 1'b0};
          cnt <= cnt + 1'b1;
        end
        SIGN: begin
          done <= 1'b1;
          ovf  <= ovf_c;
`ifdef DIV_DBZ_FLAG_EN
          dbz  <= dbz_c;
`endif
          if (ovf_c) begin
            quotient  <= sat_neg ? MIN_MAG : MAX_POS;
            remainder <= '0;
          end else begin
            quotient  <= q_neg  ? (~q_mag + 1'b1) : q_mag;
            remainder <= sign_n ? (~r_mag + 1'b1) : r_mag;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_booth_divider.sv
// Randomized and directed bench for seq_booth_divider against a plain-arithmetic
// truncating-division reference model.
module tb_seq_booth_divider;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, done, ovf;
  logic [15:0] quotient, remainder;
`ifdef DIV_DBZ_FLAG_EN
  logic        dbz;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  seq_booth_divider #(.BITWIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
`ifdef DIV_DBZ_FLAG_EN
    .dbz       (dbz),
`endif
    .ovf       (ovf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model(input logic [31:0] a, input logic [15:0] b,
                       output logic [15:0] q, output logic [15:0] r,
                       output logic o, output logic z, output int lat);
    longint sa, sb, qq, rr, qabs;
    bit     neg;
    sa = longint'(signed'(a));
    sb = longint'(signed'(b));
    if (sb == 0) begin
      z = 1'b1; o = 1'b1; r = 16'h0; lat = 2;
      q = (sa < 0) ? 16'h8000 : 16'h7FFF;
    end else begin
      z    = 1'b0;
      qq   = sa / sb;
      rr   = sa % sb;
      qabs = (qq < 0) ? -qq : qq;
      neg  = (sa < 0) != (sb < 0);
      lat  = (qabs >= 65536) ? 2 : 18;
      o    = (qq > 32767) || (qq < -32768);
      if (o) begin
        q = neg ? 16'h8000 : 16'h7FFF;
        r = 16'h0;
      end else begin
        q = qq[15:0];
        r = rr[15:0];
      end
    end
  endtask

  // abuse: 0 none, 1 extra start pulse mid-CALC, 2 reset mid-CALC
  task automatic run_op(input logic [31:0] a, input logic [15:0] b, input int abuse);
    logic [15:0] eq, er;
    logic        eo, ez;
    int          elat, lat, bcnt;
    bit          seen;
    model(a, b, eq, er, eo, ez, elat);
    @(negedge clk);
    dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = $urandom; divisor = 16'($urandom);
    bcnt = busy ? 1 : 0;
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      if (abuse == 1 && lat == 5) begin
        start = 1'b1; dividend = $urandom; divisor = 16'($urandom);
      end else start = 1'b0;
      reset = (abuse == 2 && lat == 5);
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (busy) bcnt++;
    end
    start = 1'b0;
    reset = 1'b0;
    if (abuse == 2) begin
      check("abort_no_done", 32'(seen), 32'd0);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_quotient", 32'(quotient), 32'd0);
      check("abort_remainder", 32'(remainder), 32'd0);
      check("abort_ovf", 32'(ovf), 32'd0);
    end else begin
      check("done_seen", 32'(seen), 32'd1);
      check("latency", 32'(lat), 32'(elat));
      check("busy_cycles", 32'(bcnt), 32'(elat));
      check("busy_at_done", 32'(busy), 32'd0);
      check("quotient", 32'(quotient), 32'(eq));
      check("remainder", 32'(remainder), 32'(er));
      check("ovf", 32'(ovf), 32'(eo));
`ifdef DIV_DBZ_FLAG_EN
      check("dbz", 32'(dbz), 32'(ez));
`endif
      @(posedge clk); #1;
      check("done_one_cycle", 32'(done), 32'd0);
      check("quotient_hold", 32'(quotient), 32'(eq));
      check("remainder_hold", 32'(remainder), 32'(er));
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [15:0] rb;
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_quotient", 32'(quotient), 32'd0);
    check("rst_remainder", 32'(remainder), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
`ifdef DIV_DBZ_FLAG_EN
    check("rst_dbz", 32'(dbz), 32'd0);
`endif

    run_op(32'd100,       16'd7,      0);
    run_op(32'hFFFF_FF9C, 16'd7,      0);
    run_op(32'd100,       16'hFFF9,   0);
    run_op(32'h4000_0000, 16'h8000,   0);
    run_op(32'hC000_0000, 16'h8000,   0);
    run_op(32'h0001_0000, 16'd1,      0);
    run_op(32'd32,        16'd0,      0);
    run_op(32'hFFFF_FFE0, 16'd0,      0);
    run_op(32'd0,         16'h1234,   0);
    run_op(32'h8000_0000, 16'hFFFF,   0);
    run_op(32'h7FFF_FFFF, 16'h7FFF,   0);
    run_op(32'd12345678,  16'd1000,   1);
    run_op(32'd12345678,  16'd1000,   2);
    run_op(32'hFFFF_0000, 16'd3,      0);

    for (int i = 0; i < 60; i++) begin
      ra = $urandom;
      ra = 32'(signed'(ra) >>> $urandom_range(0, 31));
      rb = 16'($urandom);
      if ($urandom_range(0, 3) == 0) rb = 16'(signed'(rb) >>> $urandom_range(4, 15));
      run_op(ra, rb, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
